// File: rtl/btn_press_decoder_if.sv
// Pin-side and event-side signals of the button press decoder.
// The decoder takes the slave modport; whoever drives the pin and consumes events takes master.
interface btn_press_decoder_if;
   logic btn_n;
   logic pressed;
   logic short_press;
   logic long_press;
   logic repeat_press;

   modport master (
      output btn_n,
      input  pressed,
      input  short_press,
      input  long_press,
      input  repeat_press
   );

   modport slave (
      input  btn_n,
      output pressed,
      output short_press,
      output long_press,
      output repeat_press
   );
endinterface

// File: rtl/btn_press_decoder.sv
// Raw active-low button pin -> synchronised, debounced level plus single-cycle
// short / long / auto-repeat press events for the colour/PWM sequencer.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | button released, waiting for debounced press
// ST_HELD   | press in progress, counting towards long-press threshold
// ST_LONG   | long press reported, emitting repeat pulses until release
module btn_press_decoder #(
   parameter int unsigned DEBOUNCE_COUNT = 480_000,
   parameter int unsigned LONG_COUNT     = 48_000_000,
   parameter int unsigned REPEAT_COUNT   = 12_000_000
) (
   input logic                CLK,
   input logic                RST_N,
   btn_press_decoder_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HELD = 2'd1;
   localparam logic [1:0] ST_LONG = 2'd2;

   localparam logic [31:0] DB_LAST   = 32'(DEBOUNCE_COUNT - 1);
   localparam logic [31:0] LONG_LAST = 32'(LONG_COUNT - 1);
   localparam logic [31:0] REP_LAST  = (REPEAT_COUNT == 0) ? 32'd0 : 32'(REPEAT_COUNT - 1);

   logic        s1_q, s1_d;
   logic        s2_q, s2_d;
   logic        raw;
   logic        pressed_q, pressed_d;
   logic [31:0] db_cnt_q, db_cnt_d;
   logic [1:0]  state_q, state_d;
   logic [31:0] hold_cnt_q, hold_cnt_d;
   logic [31:0] rep_cnt_q, rep_cnt_d;
   logic        short_q, short_d;
   logic        long_q, long_d;
   logic        repeat_q, repeat_d;

   assign raw = ~s2_q;

   always_comb begin
      s1_d      = bus.btn_n;
      s2_d      = s1_q;
      pressed_d = pressed_q;
      db_cnt_d  = '0;
      // Any cycle where raw agrees with the debounced level restarts the count.
      if (raw != pressed_q) begin
         if (db_cnt_q == DB_LAST) begin
            pressed_d = raw;
         end else begin
            db_cnt_d = db_cnt_q + 32'd1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      short_d    = 1'b0;
      long_d     = 1'b0;
      repeat_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pressed_q) begin
               state_d    = ST_HELD;
               hold_cnt_d = '0;
            end
         end
         ST_HELD: begin
            // Release is tested first so it wins over reaching the long threshold.
            if (!pressed_q) begin
               short_d = 1'b1;
               state_d = ST_IDLE;
            end else if (hold_cnt_q == LONG_LAST) begin
               long_d    = 1'b1;
               rep_cnt_d = '0;
               state_d   = ST_LONG;
            end else begin
               hold_cnt_d = hold_cnt_q + 32'd1;
            end
         end
         ST_LONG: begin
            if (!pressed_q) begin
               state_d = ST_IDLE;
            end else if (REPEAT_COUNT != 0) begin
               if (rep_cnt_q == REP_LAST) begin
                  repeat_d  = 1'b1;
                  rep_cnt_d = '0;
               end else begin
                  rep_cnt_d = rep_cnt_q + 32'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1_q       <= 1'b1;
         s2_q       <= 1'b1;
         pressed_q  <= 1'b0;
         db_cnt_q   <= '0;
         state_q    <= ST_IDLE;
         hold_cnt_q <= '0;
         rep_cnt_q  <= '0;
         short_q    <= 1'b0;
         long_q     <= 1'b0;
         repeat_q   <= 1'b0;
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         pressed_q  <= pressed_d;
         db_cnt_q   <= db_cnt_d;
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         rep_cnt_q  <= rep_cnt_d;
         short_q    <= short_d;
         long_q     <= long_d;
         repeat_q   <= repeat_d;
      end
   end

   assign bus.pressed      = pressed_q;
   assign bus.short_press  = short_q;
   assign bus.long_press   = long_q;
   assign bus.repeat_press = repeat_q;

endmodule

// File: tb/tb_btn_press_decoder.sv
// Directed bench for btn_press_decoder: glitch rejection, short/long/repeat timing,
// release-vs-long tie, async reset mid-press, and a repeat-disabled build.
module tb_btn_press_decoder;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;

   always #5 CLK = ~CLK;

   btn_press_decoder_if bus0 ();
   btn_press_decoder_if bus1 ();

   btn_press_decoder #(
      .DEBOUNCE_COUNT(4), .LONG_COUNT(20), .REPEAT_COUNT(8)
   ) u_dut (
      .CLK(CLK), .RST_N(RST_N), .bus(bus0.slave)
   );

   btn_press_decoder #(
      .DEBOUNCE_COUNT(4), .LONG_COUNT(20), .REPEAT_COUNT(0)
   ) u_dut_norep (
      .CLK(CLK), .RST_N(RST_N), .bus(bus1.slave)
   );

   int n_chk  = 0;
   int n_pass = 0;

   int t, rise_t, fall_t, n_rise;
   int n_short, short_t, n_long, long_t, n_rep, rep_first, rep_last;
   int n_long2, long2_t, n_rep2;
   int n_overlap = 0;
   logic prev_p;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic set_btn(input logic v);
      bus0.btn_n = v;
      bus1.btn_n = v;
   endtask

   task automatic start_scn();
      t = 0; rise_t = -1; fall_t = -1; n_rise = 0;
      n_short = 0; short_t = -1; n_long = 0; long_t = -1;
      n_rep = 0; rep_first = -1; rep_last = -1;
      n_long2 = 0; long2_t = -1; n_rep2 = 0;
      prev_p = bus0.pressed;
   endtask

   // Each call advances n edges; edge k of a scenario is sampled as t == k.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
         t++;
         if (bus0.pressed && !prev_p) begin
            n_rise++;
            if (rise_t < 0) rise_t = t;
         end
         if (!bus0.pressed && prev_p && fall_t < 0) fall_t = t;
         prev_p = bus0.pressed;
         if (bus0.short_press) begin
            n_short++;
            if (short_t < 0) short_t = t;
         end
         if (bus0.long_press) begin
            n_long++;
            if (long_t < 0) long_t = t;
         end
         if (bus0.repeat_press) begin
            n_rep++;
            if (rep_first < 0) rep_first = t;
            rep_last = t;
         end
         if (bus1.long_press) begin
            n_long2++;
            if (long2_t < 0) long2_t = t;
         end
         if (bus1.repeat_press) n_rep2++;
         if ((32'(bus0.short_press) + 32'(bus0.long_press) + 32'(bus0.repeat_press)) > 1)
            n_overlap++;
      end
   endtask

   // Holds the pin low for `low` edges, then releases it and runs `after` edges.
   task automatic press(input int low, input int after);
      start_scn();
      set_btn(1'b0);
      step(low);
      set_btn(1'b1);
      step(after);
   endtask

   initial begin
      set_btn(1'b1);
      RST_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_pressed", int'(bus0.pressed), 0);
      chk("rst_short", int'(bus0.short_press), 0);
      chk("rst_long", int'(bus0.long_press), 0);
      chk("rst_repeat", int'(bus0.repeat_press), 0);
      RST_N = 1'b1;
      step(5);

      // 1: three-cycle glitch is one short of the debounce threshold
      press(3, 20);
      chk("t1_rises", n_rise, 0);
      chk("t1_short", n_short, 0);
      chk("t1_long", n_long, 0);

      // 2: short press
      press(10, 20);
      chk("t2_rise_t", rise_t, 6);
      chk("t2_fall_t", fall_t, 16);
      chk("t2_n_short", n_short, 1);
      chk("t2_short_t", short_t, 17);
      chk("t2_n_long", n_long, 0);

      // 3: long press with repeats; repeat-disabled build watched in parallel
      press(60, 30);
      chk("t3_rise_t", rise_t, 6);
      chk("t3_n_long", n_long, 1);
      chk("t3_long_t", long_t, 27);
      chk("t3_n_rep", n_rep, 4);
      chk("t3_rep_first", rep_first, 35);
      chk("t3_rep_last", rep_last, 59);
      chk("t3_n_short", n_short, 0);
      chk("t3_fall_t", fall_t, 66);
      chk("t6_n_long", n_long2, 1);
      chk("t6_long_t", long2_t, 27);
      chk("t6_n_rep", n_rep2, 0);

      // 4a: pressed drops exactly when hold count hits the threshold -> short only
      press(20, 20);
      chk("t4a_n_short", n_short, 1);
      chk("t4a_short_t", short_t, 27);
      chk("t4a_n_long", n_long, 0);

      // 4b: one cycle longer -> long only
      press(21, 20);
      chk("t4b_n_long", n_long, 1);
      chk("t4b_long_t", long_t, 27);
      chk("t4b_n_short", n_short, 0);

      // 5: async reset while in LONG, landing on a repeat pulse
      start_scn();
      set_btn(1'b0);
      step(35);
      chk("t5_rep_before", int'(bus0.repeat_press), 1);
      chk("t5_press_before", int'(bus0.pressed), 1);
      RST_N = 1'b0;
      #2;
      chk("t5_async_pressed", int'(bus0.pressed), 0);
      chk("t5_async_repeat", int'(bus0.repeat_press), 0);
      step(3);
      chk("t5_hold_pressed", int'(bus0.pressed), 0);
      RST_N = 1'b1;
      start_scn();
      step(30);
      chk("t5_rise_t", rise_t, 6);
      chk("t5_long_t", long_t, 27);
      chk("t5_n_short", n_short, 0);
      start_scn();
      set_btn(1'b1);
      step(20);
      chk("t5_rel_short", n_short, 0);
      chk("t5_rel_fall", fall_t, 6);

      chk("pulse_overlap", n_overlap, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
